fetch_ibuffer_multi: RTL and testbench

FETCH_IBUFFER_MULTI -- requirements
Module: fetch_ibuffer_multi

---
 rtl/fetch_ibuffer_multi_pkg.sv | 19 +
 rtl/fetch_ibuffer_line.sv | 80 ++++++++
 rtl/fetch_ibuffer_multi.sv | 177 +++++++++++++++++
 tb/tb_fetch_ibuffer_multi.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ibuffer_multi_pkg.sv
// Shared constants for the multi-entry fetch refill buffer: entry-state encoding
// and default geometry.
package fetch_ibuffer_multi_pkg;

    localparam int DEF_ENTRIES    = 4;
    localparam int DEF_LINE_WORDS = 16;
    localparam int DEF_DATA_W     = 36;
    localparam int DEF_SNOOP_W    = 7;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    // Byte-offset width of one line address: word index plus two byte bits.
    function automatic int ofs_width(input int line_words);
        return $clog2(line_words) + 2;
    endfunction

endpackage

// File: rtl/fetch_ibuffer_line.sv
// One refill line entry: tag, per-word valid bits, data words, IDLE/FILLING/FULL
// state, and the query hit compare.
module fetch_ibuffer_line
    import fetch_ibuffer_multi_pkg::*;
#(
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int TAG_W      = 26,
    parameter int SNOOP_W    = DEF_SNOOP_W,
    parameter int WIDX_W     = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              snoop_i,
    input  logic [SNOOP_W-1:0] snoop_idx_i,
    input  logic              alloc_i,
    input  logic              keep_valid_i,
    input  logic [TAG_W-1:0]  alloc_tag_i,
    input  logic              demote_i,
    input  logic              web_i,
    input  logic [WIDX_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [TAG_W-1:0]  q_tag_i,
    input  logic [WIDX_W-1:0] q_word_i,
    output logic [1:0]        state_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              hit_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              complete_o
);

    logic [1:0]            state_q, state_d;
    logic [TAG_W-1:0]      tag_q;
    logic [LINE_WORDS-1:0] valid_q, valid_d;
    logic [DATA_W-1:0]     mem [LINE_WORDS];
    logic                  snoop_kill, filling, web_eff;

    assign snoop_kill = snoop_i && (state_q != ST_IDLE) && (tag_q[SNOOP_W-1:0] == snoop_idx_i);
    // An entry accepts refill words while it is (or is becoming) the filling one.
    assign filling    = alloc_i || ((state_q == ST_FILLING) && !demote_i);
    assign web_eff    = web_i && filling && !snoop_kill && !flush_i;

    always_comb begin
        valid_d = (alloc_i && !keep_valid_i) ? '0 : valid_q;
        if (web_eff) begin
            valid_d[waddr_i] = 1'b1;
        end
        complete_o = web_eff && (&valid_d);
        state_d    = state_q;
        if (alloc_i || (state_q == ST_FILLING)) begin
            state_d = (complete_o || !filling) ? ST_FULL : ST_FILLING;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i || snoop_kill) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if (alloc_i) begin
                tag_q <= alloc_tag_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (web_eff) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign state_o = state_q;
    assign tag_o   = tag_q;
    assign hit_o   = (state_q != ST_IDLE) && (tag_q == q_tag_i) && valid_q[q_word_i];
    assign rdata_o = mem[q_word_i];

endmodule

// File: rtl/fetch_ibuffer_multi.sv
// Multi-entry instruction refill buffer with registered fetch lookup.
// Optional one-word uncached bypass buffer: FETCH_IBUFFER_MULTI_UNCACHED_EN.
module fetch_ibuffer_multi
    import fetch_ibuffer_multi_pkg::*;
#(
    parameter int ENTRIES    = DEF_ENTRIES,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SNOOP_W    = DEF_SNOOP_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uncached_we,
    input  logic [31:0]                   uncached_addr,
    input  logic [DATA_W-1:0]             uncached_din,
    output logic                          uncached_done,
    input  logic                          refilled_wea,
    input  logic [31:0]                   refilled_addra,
    input  logic                          refilled_web,
    input  logic [$clog2(LINE_WORDS)-1:0] refilled_addrb,
    input  logic [DATA_W-1:0]             refilled_dinb,
    input  logic                          refilled_reset,
    output logic                          refilled_hit,
    output logic                          refilled_busy,
    output logic                          refilled_done,
    input  logic                          snoop_hit,
    input  logic [31:0]                   snoop_addr,
    input  logic [31:0]                   q_addr,
    output logic                          q_hit,
    output logic [DATA_W-1:0]             q_data
);

    localparam int OFS_W  = ofs_width(LINE_WORDS);
    localparam int WIDX_W = $clog2(LINE_WORDS);
    localparam int TAG_W  = 32 - OFS_W;
    localparam int EIDX_W = $clog2(ENTRIES);

    logic [1:0]         ent_state [ENTRIES];
    logic [TAG_W-1:0]   ent_tag   [ENTRIES];
    logic [DATA_W-1:0]  ent_rdata [ENTRIES];
    logic [ENTRIES-1:0] ent_hit, ent_alloc, ent_demote, ent_complete, ent_filling;
    logic [EIDX_W-1:0]  victim_q, target, match_idx, idle_idx;
    logic               match_found, idle_found, use_victim, alloc_en;
    logic               refill_hit, uc_hit;
    logic [DATA_W-1:0]  refill_data, uc_data;
    logic               q_hit_q, done_q;
    logic [DATA_W-1:0]  q_data_q;
    logic               unused_bits;

    assign alloc_en = refilled_wea && !refilled_reset;

    // Target priority: tag match, then lowest IDLE entry, then round-robin victim.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        idle_found  = 1'b0;
        idle_idx    = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if ((ent_state[i] != ST_IDLE) && (ent_tag[i] == refilled_addra[31:OFS_W])) begin
                match_found = 1'b1;
                match_idx   = EIDX_W'(i);
            end
            if (ent_state[i] == ST_IDLE) begin
                idle_found = 1'b1;
                idle_idx   = EIDX_W'(i);
            end
        end
        use_victim = !match_found && !idle_found;
        target     = match_found ? match_idx : (idle_found ? idle_idx : victim_q);
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            assign ent_alloc[gi]   = alloc_en && (target == EIDX_W'(gi));
            assign ent_demote[gi]  = alloc_en && (target != EIDX_W'(gi));
            assign ent_filling[gi] = (ent_state[gi] == ST_FILLING);

            fetch_ibuffer_line #(
                .LINE_WORDS (LINE_WORDS),
                .DATA_W     (DATA_W),
                .TAG_W      (TAG_W),
                .SNOOP_W    (SNOOP_W),
                .WIDX_W     (WIDX_W)
            ) u_line (
                .clk          (clk),
                .reset        (reset),
                .flush_i      (refilled_reset),
                .snoop_i      (snoop_hit),
                .snoop_idx_i  (snoop_addr[OFS_W+SNOOP_W-1:OFS_W]),
                .alloc_i      (ent_alloc[gi]),
                .keep_valid_i (match_found),
                .alloc_tag_i  (refilled_addra[31:OFS_W]),
                .demote_i     (ent_demote[gi]),
                .web_i        (refilled_web),
                .waddr_i      (refilled_addrb),
                .wdata_i      (refilled_dinb),
                .q_tag_i      (q_addr[31:OFS_W]),
                .q_word_i     (q_addr[OFS_W-1:2]),
                .state_o      (ent_state[gi]),
                .tag_o        (ent_tag[gi]),
                .hit_o        (ent_hit[gi]),
                .rdata_o      (ent_rdata[gi]),
                .complete_o   (ent_complete[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            victim_q <= '0;
        end else if (alloc_en && use_victim) begin
            victim_q <= victim_q + EIDX_W'(1);
        end
    end

    always_comb begin
        refill_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_hit[i]) begin
                refill_data = refill_data | ent_rdata[i];
            end
        end
    end

    assign refill_hit    = |ent_hit;
    assign refilled_hit  = refill_hit;
    assign refilled_busy = |ent_filling;

`ifdef FETCH_IBUFFER_MULTI_UNCACHED_EN
    logic              ub_valid_q;
    logic [29:0]       ub_addr_q;
    logic [DATA_W-1:0] ub_data_q;

    // The bypass word is visible for exactly the cycle after it was written.
    always_ff @(posedge clk) begin
        if (reset) begin
            ub_valid_q <= 1'b0;
        end else begin
            ub_valid_q <= uncached_we;
            if (uncached_we) begin
                ub_addr_q <= uncached_addr[31:2];
                ub_data_q <= uncached_din;
            end
        end
    end

    assign uc_hit  = ub_valid_q && (ub_addr_q == q_addr[31:2]);
    assign uc_data = ub_data_q;
    assign unused_bits = ^{uncached_addr[1:0], refilled_addra[OFS_W-1:0], q_addr[1:0],
                           snoop_addr[31:OFS_W+SNOOP_W], snoop_addr[OFS_W-1:0]};
`else
    assign uc_hit  = 1'b0;
    assign uc_data = '0;
    assign unused_bits = ^{uncached_we, uncached_addr, uncached_din,
                           refilled_addra[OFS_W-1:0], q_addr[1:0],
                           snoop_addr[31:OFS_W+SNOOP_W], snoop_addr[OFS_W-1:0]};
`endif

    assign uncached_done = uc_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            q_hit_q  <= 1'b0;
            q_data_q <= '0;
            done_q   <= 1'b0;
        end else begin
            q_hit_q  <= uc_hit || refill_hit;
            q_data_q <= uc_hit ? uc_data : refill_data;
            done_q   <= |ent_complete;
        end
    end

    assign q_hit         = q_hit_q;
    assign q_data        = q_data_q;
    assign refilled_done = done_q;

endmodule

// File: tb/tb_fetch_ibuffer_multi.sv
// Directed plus randomized bench for fetch_ibuffer_multi against a line-level
// behavioural model; honours FETCH_IBUFFER_MULTI_UNCACHED_EN like the design.
module tb_fetch_ibuffer_multi;

    localparam int ENTRIES    = 4;
    localparam int LINE_WORDS = 16;
    localparam int DATA_W     = 36;
    localparam int SNOOP_W    = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic              uncached_we;
    logic [31:0]       uncached_addr;
    logic [DATA_W-1:0] uncached_din;
    logic              uncached_done;
    logic              refilled_wea;
    logic [31:0]       refilled_addra;
    logic              refilled_web;
    logic [3:0]        refilled_addrb;
    logic [DATA_W-1:0] refilled_dinb;
    logic              refilled_reset;
    logic              refilled_hit;
    logic              refilled_busy;
    logic              refilled_done;
    logic              snoop_hit;
    logic [31:0]       snoop_addr;
    logic [31:0]       q_addr;
    logic              q_hit;
    logic [DATA_W-1:0] q_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: per-entry state (0 idle, 1 filling, 2 full), line tag, valid map, words.
    int                m_state [ENTRIES];
    logic [25:0]       m_tag   [ENTRIES];
    bit                m_valid [ENTRIES][LINE_WORDS];
    logic [DATA_W-1:0] m_data  [ENTRIES][LINE_WORDS];
    int                m_victim;
    bit                m_ub_valid;
    logic [29:0]       m_ub_addr;
    logic [DATA_W-1:0] m_ub_data;
    bit                m_qhit;
    logic [DATA_W-1:0] m_qdata;
    bit                m_done;

    fetch_ibuffer_multi #(
        .ENTRIES(ENTRIES), .LINE_WORDS(LINE_WORDS), .DATA_W(DATA_W), .SNOOP_W(SNOOP_W)
    ) dut (
        .clk(clk), .reset(reset),
        .uncached_we(uncached_we), .uncached_addr(uncached_addr),
        .uncached_din(uncached_din), .uncached_done(uncached_done),
        .refilled_wea(refilled_wea), .refilled_addra(refilled_addra),
        .refilled_web(refilled_web), .refilled_addrb(refilled_addrb),
        .refilled_dinb(refilled_dinb), .refilled_reset(refilled_reset),
        .refilled_hit(refilled_hit), .refilled_busy(refilled_busy),
        .refilled_done(refilled_done), .snoop_hit(snoop_hit), .snoop_addr(snoop_addr),
        .q_addr(q_addr), .q_hit(q_hit), .q_data(q_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int e = 0; e < ENTRIES; e++) begin
            m_state[e] = 0;
            for (int w = 0; w < LINE_WORDS; w++) m_valid[e][w] = 1'b0;
        end
        m_victim   = 0;
        m_ub_valid = 1'b0;
        m_qhit     = 1'b0;
        m_qdata    = '0;
        m_done     = 1'b0;
    endtask

    task automatic model_lookup(output bit rhit, output logic [DATA_W-1:0] rdata,
                                output bit busy, output bit ud);
        rhit  = 1'b0;
        rdata = '0;
        busy  = 1'b0;
        ud    = 1'b0;
        for (int e = 0; e < ENTRIES; e++) begin
            if (m_state[e] == 1) busy = 1'b1;
            if (m_state[e] != 0 && m_tag[e] == q_addr[31:6] && m_valid[e][q_addr[5:2]]) begin
                rhit  = 1'b1;
                rdata = m_data[e][q_addr[5:2]];
            end
        end
`ifdef FETCH_IBUFFER_MULTI_UNCACHED_EN
        ud = m_ub_valid && (m_ub_addr == q_addr[31:2]);
`endif
    endtask

    task automatic model_update(input bit rhit, input logic [DATA_W-1:0] rdata, input bit ud);
        bit   kill [ENTRIES];
        int   tgt;
        bit   fresh;
        bit   all_v;
        if (reset) begin
            model_reset();
            return;
        end
        m_qhit  = ud || rhit;
        m_qdata = ud ? m_ub_data : rdata;
        m_done  = 1'b0;
`ifdef FETCH_IBUFFER_MULTI_UNCACHED_EN
        m_ub_valid = uncached_we;
        if (uncached_we) begin
            m_ub_addr = uncached_addr[31:2];
            m_ub_data = uncached_din;
        end
`endif
        if (refilled_reset) begin
            for (int e = 0; e < ENTRIES; e++) begin
                m_state[e] = 0;
                for (int w = 0; w < LINE_WORDS; w++) m_valid[e][w] = 1'b0;
            end
            return;
        end
        for (int e = 0; e < ENTRIES; e++)
            kill[e] = snoop_hit && m_state[e] != 0 && m_tag[e][6:0] == snoop_addr[12:6];
        tgt = -1;
        if (refilled_wea) begin
            for (int e = 0; e < ENTRIES; e++)
                if (tgt < 0 && m_state[e] != 0 && m_tag[e] == refilled_addra[31:6]) tgt = e;
            fresh = (tgt < 0);
            for (int e = 0; e < ENTRIES; e++)
                if (tgt < 0 && m_state[e] == 0) tgt = e;
            if (tgt < 0) begin
                tgt      = m_victim;
                m_victim = (m_victim + 1) % ENTRIES;
            end
            for (int e = 0; e < ENTRIES; e++)
                if (e != tgt && m_state[e] == 1) m_state[e] = 2;
            m_state[tgt] = 1;
            m_tag[tgt]   = refilled_addra[31:6];
            if (fresh) for (int w = 0; w < LINE_WORDS; w++) m_valid[tgt][w] = 1'b0;
        end else begin
            for (int e = 0; e < ENTRIES; e++) if (m_state[e] == 1) tgt = e;
        end
        if (refilled_web && tgt >= 0 && !kill[tgt]) begin
            m_data[tgt][refilled_addrb]  = refilled_dinb;
            m_valid[tgt][refilled_addrb] = 1'b1;
            all_v = 1'b1;
            for (int w = 0; w < LINE_WORDS; w++) if (!m_valid[tgt][w]) all_v = 1'b0;
            if (all_v) begin
                m_state[tgt] = 2;
                m_done       = 1'b1;
            end
        end
        for (int e = 0; e < ENTRIES; e++) begin
            if (kill[e]) begin
                m_state[e] = 0;
                for (int w = 0; w < LINE_WORDS; w++) m_valid[e][w] = 1'b0;
            end
        end
    endtask

    // One clock cycle with the inputs currently driven (called just after negedge).
    task automatic step();
        bit                rhit, busy, ud;
        logic [DATA_W-1:0] rdata;
        #1;
        model_lookup(rhit, rdata, busy, ud);
        chk("refilled_hit", refilled_hit, rhit);
        chk("refilled_busy", refilled_busy, busy);
        chk("uncached_done", uncached_done, ud);
        model_update(rhit, rdata, ud);
        @(posedge clk);
        #1;
        chk("q_hit", q_hit, m_qhit);
        if (m_qhit || reset) chk("q_data", q_data, m_qdata);
        chk("refilled_done", refilled_done, m_done);
        $display("cyc %0d wea=%b web=%b q_addr=%h q_hit=%b q_data=%h done=%b",
                 cyc, refilled_wea, refilled_web, q_addr, q_hit, q_data, refilled_done);
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_pulses();
        reset          = 1'b0;
        uncached_we    = 1'b0;
        refilled_wea   = 1'b0;
        refilled_web   = 1'b0;
        refilled_reset = 1'b0;
        snoop_hit      = 1'b0;
    endtask

    task automatic fill_line(input logic [31:0] addr, input logic [DATA_W-1:0] base);
        clear_pulses();
        refilled_wea   = 1'b1;
        refilled_addra = addr;
        step();
        clear_pulses();
        for (int w = 0; w < LINE_WORDS; w++) begin
            refilled_web   = 1'b1;
            refilled_addrb = w[3:0];
            refilled_dinb  = base + DATA_W'(w);
            step();
        end
        chk("fill_done_pulse", refilled_done, 1);
        clear_pulses();
        step();
        chk("fill_done_cleared", refilled_done, 0);
    endtask

    function automatic logic [31:0] pick_line();
        case ($urandom_range(0, 6))
            0: return 32'h0000_1000;
            1: return 32'h0000_1040;
            2: return 32'h0000_1080;
            3: return 32'h0000_10C0;
            4: return 32'h0000_1100;
            5: return 32'h0000_1140;
            default: return 32'h0000_3000;
        endcase
    endfunction

    initial begin
        logic [31:0] last_uc;
        reset = 1'b1;
        uncached_we = 1'b0; uncached_addr = '0; uncached_din = '0;
        refilled_wea = 1'b0; refilled_addra = '0; refilled_web = 1'b0;
        refilled_addrb = '0; refilled_dinb = '0; refilled_reset = 1'b0;
        snoop_hit = 1'b0; snoop_addr = '0; q_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        step();
        chk("reset_q_hit", q_hit, 0);
        chk("reset_q_data", q_data, 0);
        chk("reset_done", refilled_done, 0);
        chk("reset_busy", refilled_busy, 0);

        // Full line fill and word lookup.
        q_addr = 32'h0000_1024;
        fill_line(32'h0000_1000, 36'h100);
        q_addr = 32'h0000_1024;
        step();
        chk("line_q_hit", q_hit, 1);
        chk("line_q_data", q_data, 36'h109);

        // Replacement order once all entries are FULL.
        fill_line(32'h0000_1040, 36'h200);
        fill_line(32'h0000_1080, 36'h300);
        fill_line(32'h0000_10C0, 36'h400);
        fill_line(32'h0000_1100, 36'h500);
        fill_line(32'h0000_1140, 36'h600);
        q_addr = 32'h0000_1004; step();
        chk("victim0_miss", q_hit, 0);
        q_addr = 32'h0000_1048; step();
        chk("victim1_miss", q_hit, 0);
        q_addr = 32'h0000_1088; step();
        chk("kept_hit", q_hit, 1);
        chk("kept_data", q_data, 36'h302);
        q_addr = 32'h0000_1144; step();
        chk("new_data", q_data, 36'h601);

        // Partial fill then snoop.
        clear_pulses(); refilled_reset = 1'b1; step();
        clear_pulses(); refilled_wea = 1'b1; refilled_addra = 32'h0000_1000; step();
        for (int w = 0; w < 4; w++) begin
            clear_pulses(); refilled_web = 1'b1; refilled_addrb = w[3:0];
            refilled_dinb = 36'h700 + DATA_W'(w); step();
        end
        clear_pulses(); snoop_hit = 1'b1; snoop_addr = 32'h0000_1000; q_addr = 32'h0000_1000;
        step();
        clear_pulses(); step();
        chk("snoop_busy", refilled_busy, 0);
        chk("snoop_rhit", refilled_hit, 0);

        // Uncached bypass word.
        clear_pulses(); uncached_we = 1'b1; uncached_addr = 32'h0000_2008; uncached_din = 36'h5A;
        step();
        clear_pulses(); q_addr = 32'h0000_2008; step();
`ifdef FETCH_IBUFFER_MULTI_UNCACHED_EN
        chk("uc_q_hit", q_hit, 1);
        chk("uc_q_data", q_data, 36'h5A);
        chk("uc_done_gone", uncached_done, 0);
`else
        chk("uc_q_hit_disabled", q_hit, 0);
`endif
        step();

        // Reset in the middle of a fill.
        clear_pulses(); refilled_wea = 1'b1; refilled_addra = 32'h0000_1180; step();
        for (int w = 0; w < 8; w++) begin
            clear_pulses(); refilled_web = 1'b1; refilled_addrb = w[3:0];
            refilled_dinb = 36'h800 + DATA_W'(w);
            if (w == 7) reset = 1'b1;
            step();
        end
        chk("midrst_q_hit", q_hit, 0);
        chk("midrst_q_data", q_data, 0);
        chk("midrst_busy", refilled_busy, 0);
        chk("midrst_done", refilled_done, 0);
        clear_pulses(); q_addr = 32'h0000_1184; step();
        chk("midrst_line_miss", q_hit, 0);

        // Flush wins over a coincident refill word.
        clear_pulses(); refilled_wea = 1'b1; refilled_addra = 32'h0000_11C0; step();
        clear_pulses(); refilled_web = 1'b1; refilled_addrb = 4'd0; refilled_dinb = 36'h900; step();
        clear_pulses(); refilled_web = 1'b1; refilled_addrb = 4'd1; refilled_dinb = 36'h901;
        refilled_reset = 1'b1; step();
        clear_pulses(); q_addr = 32'h0000_11C4; step();
        chk("flush_busy", refilled_busy, 0);
        chk("flush_q_hit", q_hit, 0);

        // Randomized traffic over a small line pool (0x3000 aliases 0x1000 for snoop).
        last_uc = 32'h0000_1000;
        for (int c = 0; c < 700; c++) begin
            clear_pulses();
            refilled_wea   = ($urandom_range(0, 99) < 4);
            refilled_addra = pick_line();
            refilled_web   = ($urandom_range(0, 99) < 65);
            refilled_addrb = 4'($urandom_range(0, 15));
            refilled_dinb  = DATA_W'({$urandom(), $urandom()});
            refilled_reset = ($urandom_range(0, 299) == 0);
            snoop_hit      = ($urandom_range(0, 99) < 2);
            snoop_addr     = pick_line() + 32'($urandom_range(0, 15)) * 4;
            uncached_we    = ($urandom_range(0, 99) < 10);
            uncached_addr  = pick_line() + 32'($urandom_range(0, 15)) * 4;
            uncached_din   = DATA_W'({$urandom(), $urandom()});
            q_addr         = ($urandom_range(0, 99) < 25) ? last_uc
                                                          : pick_line() + 32'($urandom_range(0, 15)) * 4;
            reset          = ($urandom_range(0, 499) == 0);
            if (uncached_we) last_uc = uncached_addr;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
